// File: rtl/button_debouncer.sv
// button_debouncer: four independent channels of polarity fix, two-flop synchronizer,
// stability counter and one-cycle press pulse. Revision 1.0.
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  output logic       button_1,
  output logic       button_2,
  output logic       button_3,
  output logic       button_4,
  output logic [3:0] pressed
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] level;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] pulse;

  assign level = ACTIVE_LOW ? ~buttons_raw : buttons_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic             stable_q;
      logic             pulse_q;

      // Any cycle where sync2 agrees with the accepted level restarts qualification.
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt      <= '0;
          stable_q <= 1'b0;
          pulse_q  <= 1'b0;
        end else begin
          pulse_q <= 1'b0;
          if (sync2[i] == stable_q) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            cnt      <= '0;
            stable_q <= sync2[i];
            pulse_q  <= sync2[i];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end

      assign stable[i] = stable_q;
      assign pulse[i]  = pulse_q;
    end
  endgenerate

  assign pressed  = stable;
  assign button_1 = pulse[0];
  assign button_2 = pulse[1];
  assign button_3 = pulse[2];
  assign button_4 = pulse[3];

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of button_debouncer with DEBOUNCE_CYCLES=4, ACTIVE_LOW=0.
`default_nettype none

module tb_button_debouncer;

  logic       clock;
  logic       reset;
  logic [3:0] buttons_raw;
  logic       button_1;
  logic       button_2;
  logic       button_3;
  logic       button_4;
  logic [3:0] pressed;
  logic [3:0] btns;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .buttons_raw(buttons_raw),
    .button_1   (button_1),
    .button_2   (button_2),
    .button_3   (button_3),
    .button_4   (button_4),
    .pressed    (pressed)
  );

  assign btns = {button_4, button_3, button_2, button_1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge, then check pulses and levels 1 ns after it.
  task automatic step(input string tag, input logic [3:0] eb, input logic [3:0] ep);
    @(posedge clock);
    #1;
    total++;
    assert (btns === eb) else begin
      bad++;
      $error("FAIL %s pulses observed=%b expected=%b", tag, btns, eb);
    end
    total++;
    assert (pressed === ep) else begin
      bad++;
      $error("FAIL %s pressed observed=%b expected=%b", tag, pressed, ep);
    end
  endtask

  initial begin
    reset       = 1'b1;
    buttons_raw = 4'b1111;

    // Reset held with all buttons down, then one joint pulse 6 edges after release.
    for (int t = 1; t <= 3; t++) step("reset_hold", 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int t = 1; t <= 8; t++)
      step("reset_release", (t == 6) ? 4'b1111 : 4'b0000, (t >= 6) ? 4'b1111 : 4'b0000);
    buttons_raw = 4'b0000;
    for (int t = 1; t <= 8; t++)
      step("reset_unpress", 4'b0000, (t >= 6) ? 4'b0000 : 4'b1111);

    // Clean press on button 2, held long, then released.
    buttons_raw = 4'b0010;
    for (int t = 1; t <= 15; t++)
      step("clean_press", (t == 6) ? 4'b0010 : 4'b0000, (t >= 6) ? 4'b0010 : 4'b0000);
    buttons_raw = 4'b0000;
    for (int t = 1; t <= 8; t++)
      step("clean_release", 4'b0000, (t >= 6) ? 4'b0000 : 4'b0010);

    // Bounce rejection: 1,1,1,0 repeated five times, never four in a row.
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 4; t++) begin
        buttons_raw = (t < 3) ? 4'b0001 : 4'b0000;
        step("bounce_reject", 4'b0000, 4'b0000);
      end
    end
    buttons_raw = 4'b0000;
    for (int t = 1; t <= 6; t++) step("bounce_quiet", 4'b0000, 4'b0000);

    // Bounce then settle: 1,0,1,1,0 then steady 1 starting at tick 6.
    begin
      logic [5:0] seq;
      seq = 6'b101101;
      for (int t = 1; t <= 15; t++) begin
        if (t <= 6) buttons_raw = {3'b000, seq[6 - t]};
        else        buttons_raw = 4'b0001;
        step("bounce_settle", (t == 11) ? 4'b0001 : 4'b0000, (t >= 11) ? 4'b0001 : 4'b0000);
      end
    end
    buttons_raw = 4'b0000;
    for (int t = 1; t <= 8; t++)
      step("settle_release", 4'b0000, (t >= 6) ? 4'b0000 : 4'b0001);

    // Buttons 3 and 4 together, then released together.
    buttons_raw = 4'b1100;
    for (int t = 1; t <= 8; t++)
      step("simul_press", (t == 6) ? 4'b1100 : 4'b0000, (t >= 6) ? 4'b1100 : 4'b0000);
    buttons_raw = 4'b0000;
    for (int t = 1; t <= 8; t++)
      step("simul_release", 4'b0000, (t >= 6) ? 4'b0000 : 4'b1100);

    // Reset while the counter sits at 2 discards the count; pulse comes 6 edges after release.
    buttons_raw = 4'b0001;
    for (int t = 1; t <= 4; t++) step("midcount_pre", 4'b0000, 4'b0000);
    reset = 1'b1;
    for (int t = 1; t <= 2; t++) step("midcount_reset", 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int t = 1; t <= 10; t++)
      step("midcount_after", (t == 6) ? 4'b0001 : 4'b0000, (t >= 6) ? 4'b0001 : 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
